// File: rtl/sram_arbiter_if.sv
// Requester-side command/return bundle for the SRAM arbiter.
// The master modport is the requester, the slave modport is the arbiter.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        sel;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, sel, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, sel, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester SRAM port arbiter: weighted round-robin with burst limit,
// one registered command per cycle, in-order tagged read returns.
module sram_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  sram_arbiter_if.slave     m0,
  sram_arbiter_if.slave     m1,
  output logic              sram_ce_o,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [3:0]        sram_sel_o,
  output logic [DATA_W-1:0] sram_data_o,
  input  logic [DATA_W-1:0] sram_data_i
);

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  logic              last_grant;
  logic [3:0]        burst_cnt;
  logic              keep;
  logic              pick;
  logic              any_gnt;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [3:0]        cmd_sel;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rd_v;
  logic              rd_tag;
  logic              ret_v;
  logic              ret_tag;

  // burst_cnt==0 only right after reset: no burst yet, so m0 wins first
  assign keep = (burst_cnt != 4'd0) && (burst_cnt < BURST_LIM);

  always_comb begin
    any_gnt = 1'b0;
    pick    = 1'b0;
    unique case (1'b1)
      (m0.req && m1.req): begin
        any_gnt = 1'b1;
        pick    = keep ? last_grant : ~last_grant;
      end
      (m0.req && !m1.req): begin
        any_gnt = 1'b1;
        pick    = 1'b0;
      end
      (!m0.req && m1.req): begin
        any_gnt = 1'b1;
        pick    = 1'b1;
      end
      default: begin
        any_gnt = 1'b0;
        pick    = 1'b0;
      end
    endcase
  end

  assign m0.gnt = any_gnt & ~pick;
  assign m1.gnt = any_gnt & pick;

  assign cmd_we    = pick ? m1.we    : m0.we;
  assign cmd_addr  = pick ? m1.addr  : m0.addr;
  assign cmd_sel   = pick ? m1.sel   : m0.sel;
  assign cmd_wdata = pick ? m1.wdata : m0.wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant  <= 1'b1;
      burst_cnt   <= 4'd0;
      sram_ce_o   <= 1'b0;
      sram_we_o   <= 1'b0;
      sram_addr_o <= '0;
      sram_sel_o  <= '0;
      sram_data_o <= '0;
      rd_v        <= 1'b0;
      rd_tag      <= 1'b0;
      ret_v       <= 1'b0;
      ret_tag     <= 1'b0;
    end else begin
      sram_ce_o <= any_gnt;
      rd_v      <= any_gnt & ~cmd_we;
      rd_tag    <= pick;
      ret_v     <= rd_v;
      ret_tag   <= rd_tag;
      if (any_gnt) begin
        sram_we_o   <= cmd_we;
        sram_addr_o <= cmd_addr;
        sram_sel_o  <= cmd_sel;
        sram_data_o <= cmd_wdata;
        last_grant  <= pick;
        if (pick == last_grant)
          burst_cnt <= (burst_cnt == 4'hF) ? 4'hF
                                           : burst_cnt + 4'd1;
        else
          burst_cnt <= 4'd1;
      end
    end
  end

  assign m0.rvalid = ret_v & ~ret_tag;
  assign m1.rvalid = ret_v & ret_tag;
  assign m0.rdata  = sram_data_i;
  assign m1.rdata  = sram_data_i;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reset, read return, byte writes,
// burst-limited contention (MAX_BURST 4 and 1), mid-flight reset.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ce_b;
  logic        we_b;
  logic [31:0] addr_b;
  logic [3:0]  sel_b;
  logic [31:0] wdata_b;
  logic [31:0] rdata_b;
  logic [31:0] mem [0:63];

  int n_chk;
  int n_fail;

  sram_arbiter_if a0 ();
  sram_arbiter_if a1 ();
  sram_arbiter_if b0 ();
  sram_arbiter_if b1 ();

  sram_arbiter #(.MAX_BURST(4)) u0 (
    .clk(clk), .rst(rst), .m0(a0), .m1(a1),
    .sram_ce_o(ce), .sram_we_o(we), .sram_addr_o(addr),
    .sram_sel_o(sel), .sram_data_o(wdata), .sram_data_i(rdata)
  );

  sram_arbiter #(.MAX_BURST(1)) u1 (
    .clk(clk), .rst(rst), .m0(b0), .m1(b1),
    .sram_ce_o(ce_b), .sram_we_o(we_b), .sram_addr_o(addr_b),
    .sram_sel_o(sel_b), .sram_data_o(wdata_b), .sram_data_i(rdata_b)
  );

  assign rdata_b = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-enabled synchronous SRAM, read data one cycle after command
  always @(posedge clk) begin
    if (ce) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) mem[addr[7:2]][b*8 +: 8] <= wdata[b*8 +: 8];
      end else begin
        rdata <= mem[addr[7:2]];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic set0(input logic r, input logic w,
                      input logic [31:0] ad, input logic [3:0] s,
                      input logic [31:0] d);
    a0.req = r; a0.we = w; a0.addr = ad;
    a0.sel = s; a0.wdata = d;
  endtask

  task automatic set1(input logic r, input logic w,
                      input logic [31:0] ad, input logic [3:0] s,
                      input logic [31:0] d);
    a1.req = r; a1.we = w; a1.addr = ad;
    a1.sel = s; a1.wdata = d;
  endtask

  logic exp0 [12];
  logic [31:0] eaddr;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rdata  = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    exp0 = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
    rst = 1'b0;
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    b0.req = 0; b0.we = 1; b0.addr = 32'h40;
    b0.sel = 4'hF; b0.wdata = 0;
    b1.req = 0; b1.we = 1; b1.addr = 32'h44;
    b1.sel = 4'hF; b1.wdata = 0;
    repeat (2) nxt;
    rst = 1'b1;

    nxt; #1;
    chk("rst_ce", ce, 0);
    chk("rst_addr", addr, 0);
    chk("rst_rv0", a0.rvalid, 0);
    chk("rst_rv1", a1.rvalid, 0);

    nxt;
    set0(1, 0, 32'h0, 4'hF, 0);
    set1(1, 0, 32'h4, 4'hF, 0);
    #1;
    chk("first_g0", a0.gnt, 1);
    chk("first_g1", a1.gnt, 0);
    nxt;
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    #1;
    chk("first_ce", ce, 1);
    chk("first_addr", addr, 32'h0);
    nxt; #1;
    chk("first_rv0", a0.rvalid, 1);

    nxt;
    set1(1, 1, 32'h10, 4'hF, 32'hDEADBEEF);
    #1;
    chk("wr_g1", a1.gnt, 1);
    chk("wr_g0", a0.gnt, 0);
    nxt;
    set1(0, 0, 0, 0, 0);
    set0(1, 0, 32'h10, 4'hF, 0);
    #1;
    chk("rd_g0", a0.gnt, 1);
    chk("wr_ce", ce, 1);
    chk("wr_we", we, 1);
    chk("wr_addr", addr, 32'h10);
    chk("wr_data", wdata, 32'hDEADBEEF);
    chk("wr_sel", sel, 4'hF);
    nxt;
    set0(0, 0, 0, 0, 0);
    #1;
    chk("rd_ce", ce, 1);
    chk("rd_we", we, 0);
    chk("rd_rv_early", a0.rvalid, 0);
    nxt; #1;
    chk("rd_rv0", a0.rvalid, 1);
    chk("rd_data", a0.rdata, 32'hDEADBEEF);
    chk("rd_rv1", a1.rvalid, 0);
    chk("idle_ce", ce, 0);
    chk("idle_hold", addr, 32'h10);
    nxt; #1;
    chk("rd_rv_late", a0.rvalid, 0);

    nxt;
    set1(1, 1, 32'h20, 4'hF, 32'h11223344);
    nxt;
    set1(1, 1, 32'h20, 4'h8, 32'hAA000000);
    #1;
    chk("bw_g1", a1.gnt, 1);
    nxt;
    set1(0, 0, 0, 0, 0);
    set0(1, 0, 32'h20, 4'hF, 0);
    #1;
    chk("bw_sel", sel, 4'h8);
    nxt;
    set0(0, 0, 0, 0, 0);
    nxt; #1;
    chk("bw_rv0", a0.rvalid, 1);
    chk("bw_data", a0.rdata, 32'hAA223344);
    chk("bw_rv1", a1.rvalid, 0);

    nxt; #3;
    rst = 1'b0;
    #1;
    chk("mrst_ce", ce, 0);
    chk("mrst_addr", addr, 0);
    chk("mrst_sel", sel, 0);
    chk("mrst_data", wdata, 0);
    nxt;
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      nxt;
      if (i == 0) begin
        set0(1, 0, 32'h100, 4'hF, 0);
        set1(1, 0, 32'h200, 4'hF, 0);
        b0.req = 1;
        b1.req = 1;
      end
      #1;
      chk($sformatf("ct_g0_%0d", i), a0.gnt, exp0[i]);
      chk($sformatf("ct_g1_%0d", i), a1.gnt, !exp0[i]);
      chk($sformatf("alt_g0_%0d", i), b0.gnt, (i % 2) == 0);
      chk($sformatf("alt_g1_%0d", i), b1.gnt, (i % 2) == 1);
      if (i > 0) begin
        eaddr = exp0[i-1] ? 32'h100 : 32'h200;
        chk($sformatf("ct_ce_%0d", i), ce, 1);
        chk($sformatf("ct_addr_%0d", i), addr, eaddr);
      end
    end
    nxt;
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    b0.req = 0;
    b1.req = 0;
    repeat (3) nxt;

    nxt;
    set0(1, 0, 32'h10, 4'hF, 0);
    #1;
    chk("mf_g0", a0.gnt, 1);
    nxt;
    set0(0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("mf_rv_a", a0.rvalid, 0);
    nxt;
    rst = 1'b1;
    #1;
    chk("mf_rv_b", a0.rvalid, 0);
    nxt; #1;
    chk("mf_rv_c", a0.rvalid, 0);
    nxt;
    set0(1, 0, 32'h10, 4'hF, 0);
    set1(1, 0, 32'h20, 4'hF, 0);
    #1;
    chk("mf_g0_after", a0.gnt, 1);
    chk("mf_g1_after", a1.gnt, 0);
    nxt;
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    repeat (3) nxt;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
